// File: rtl/keypad_matrix_emulator_if.sv
// Key submission bus between a test sequencer (master) and the keypad
// emulator (slave): one key code per valid/ready handshake plus abort and
// status returns.
interface keypad_matrix_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       key_abort;
  logic       busy;
  logic       key_error;

  modport master (
    output key_valid, key_code, key_abort,
    input  key_ready, busy, key_error
  );

  modport slave (
    input  key_valid, key_code, key_abort,
    output key_ready, busy, key_error
  );
endinterface

// File: rtl/keypad_matrix_emulator.sv
// 4x4 membrane keypad emulator. Presses one key per handshake with contact
// bounce, holds it, releases it with bounce and then enforces an open gap.
// The column return is combinational from the scanner's row strobe so the
// scanner sees the contact in the same cycle it drives the row.
module keypad_matrix_emulator #(
  parameter int BOUNCE_PHASES = 6,
  parameter int BOUNCE_PERIOD = 3,
  parameter int HOLD_CYCLES   = 100,
  parameter int GAP_CYCLES    = 60
) (
  input  logic                           clk,
  input  logic                           rst,
  keypad_matrix_emulator_if.slave        kbus,
  input  logic [3:0]                     lin_matriz,
  output logic [3:0]                     col_matriz,
  output logic                           contact
);

  localparam int CNT_MAX0 = (BOUNCE_PERIOD > HOLD_CYCLES) ? BOUNCE_PERIOD : HOLD_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > GAP_CYCLES) ? CNT_MAX0 : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  // A zero-phase build still needs a legal one-bit phase register.
  localparam int PH_W     = (BOUNCE_PHASES > 0) ? $clog2(BOUNCE_PHASES + 1) : 1;

  localparam logic [CNT_W-1:0] PER_LOAD  = CNT_W'(BOUNCE_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BOUNCE_PHASES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    REL_BOUNCE,
    GAP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PH_W-1:0]  phase_q;
  logic             contact_q;
  logic             ready_q;
  logic             busy_q;
  logic             err_q;
  logic [3:0]       row_q;
  logic [3:0]       col_q;

  // Codes 0x0-0xB are keys; 0xC-0xF are rejected with an error pulse.
  function automatic logic code_ok(input logic [3:0] k);
    return (k <= 4'hB);
  endfunction

  // Active-low row of a key: 1-3 top row, 4-6, 7-9, then '*','0','#'.
  function automatic logic [3:0] key_row(input logic [3:0] k);
    case (k)
      4'h1, 4'h2, 4'h3: return 4'b0111;
      4'h4, 4'h5, 4'h6: return 4'b1011;
      4'h7, 4'h8, 4'h9: return 4'b1101;
      default:          return 4'b1110;
    endcase
  endfunction

  // Active-low column of a key; the fourth column (1110) is never used.
  function automatic logic [3:0] key_col(input logic [3:0] k);
    case (k)
      4'h1, 4'h4, 4'h7, 4'hA: return 4'b0111;
      4'h2, 4'h5, 4'h8, 4'h0: return 4'b1011;
      default:                return 4'b1101;
    endcase
  endfunction

  // Only a single strobed row can ever complete a circuit.
  function automatic logic one_low(input logic [3:0] v);
    case (v)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Press/hold/release/gap sequencer with registered contact and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      contact_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      row_q     <= 4'b1111;
      col_q     <= 4'b1111;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (kbus.key_valid && ready_q) begin
            if (code_ok(kbus.key_code)) begin
              row_q     <= key_row(kbus.key_code);
              col_q     <= key_col(kbus.key_code);
              contact_q <= 1'b1;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
              phase_q   <= '0;
              if (BOUNCE_PHASES > 0) begin
                state_q <= PRESS_BOUNCE;
                cnt_q   <= PER_LOAD;
              end else begin
                state_q <= HOLD;
                cnt_q   <= HOLD_LOAD;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        PRESS_BOUNCE: begin
          if (kbus.key_abort) begin
            state_q   <= GAP;
            cnt_q     <= GAP_LOAD;
            contact_q <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (phase_q == PH_LAST) begin
            state_q   <= HOLD;
            cnt_q     <= HOLD_LOAD;
            contact_q <= 1'b1;
          end else begin
            // Next phase p+1 is closed when p+1 is even, i.e. when p is odd.
            phase_q   <= phase_q + 1'b1;
            cnt_q     <= PER_LOAD;
            contact_q <= phase_q[0];
          end
        end

        HOLD: begin
          if (kbus.key_abort) begin
            state_q   <= GAP;
            cnt_q     <= GAP_LOAD;
            contact_q <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (BOUNCE_PHASES > 0) begin
            state_q   <= REL_BOUNCE;
            cnt_q     <= PER_LOAD;
            phase_q   <= '0;
            contact_q <= 1'b0;
          end else begin
            state_q   <= GAP;
            cnt_q     <= GAP_LOAD;
            contact_q <= 1'b0;
          end
        end

        REL_BOUNCE: begin
          if (kbus.key_abort) begin
            state_q   <= GAP;
            cnt_q     <= GAP_LOAD;
            contact_q <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (phase_q == PH_LAST) begin
            state_q   <= GAP;
            cnt_q     <= GAP_LOAD;
            contact_q <= 1'b0;
          end else begin
            // Release polarity is inverted: odd phases bounce closed.
            phase_q   <= phase_q + 1'b1;
            cnt_q     <= PER_LOAD;
            contact_q <= ~phase_q[0];
          end
        end

        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          contact_q <= 1'b0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Column return follows the scanner's row strobe within the same cycle.
  always_comb begin
    col_matriz = 4'b1111;
    if (contact_q && one_low(lin_matriz) && (lin_matriz == row_q)) begin
      col_matriz = col_q;
    end
  end

  assign contact        = contact_q;
  assign kbus.key_ready = ready_q;
  assign kbus.busy      = busy_q;
  assign kbus.key_error = err_q;

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable model of the 4x4 membrane keypad seen by the keypad scanner: samples the active-low row strobe `lin_matriz` and drives the active-low column return `col_matriz`.
- A test sequencer or self-test FSM submits one key code per valid/ready handshake.
- The block presses the key with contact bounce, holds it, releases it with bounce, then waits a mandatory gap.
- Used for on-FPGA self-test of the lock and in system benches in place of the physical keypad.

Parameters:
- BOUNCE_PHASES, 6, number of alternating contact phases on press and on release (0 = clean edges).
- BOUNCE_PERIOD, 3, clock cycles per bounce phase (>=1).
- HOLD_CYCLES, 100, cycles contact is held stably closed after press bounce (>=1).
- GAP_CYCLES, 60, cycles contact is held open after release bounce before the next key is accepted (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key_valid  in  1  request to press key_code
- key_code  in  4  0x0-0x9 digits, 0xA = '*', 0xB = '#'
- key_ready  out  1  block can accept a key
- key_abort  in  1  force immediate release
- lin_matriz  in  4  active-low row strobe from the scanner
- col_matriz  out  4  active-low column return (1111 = no key)
- busy  out  1  press sequence in progress
- key_error  out  1  one-cycle pulse on an accepted invalid code
- contact  out  1  registered internal switch state, for debug

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE; contact=0, key_ready=1, busy=0, key_error=0.
  - Latched row/col = 1111.
  - A reset mid-sequence opens the contact from the next cycle.
- Key map (row, col), active-low:
  - 1:(0111,0111)  2:(0111,1011)  3:(0111,1101)
  - 4:(1011,0111)  5:(1011,1011)  6:(1011,1101)
  - 7:(1101,0111)  8:(1101,1011)  9:(1101,1101)
  - *:(1110,0111)  0:(1110,1011)  #:(1110,1101)
  - Column 1110 is never driven.
- col_matriz (combinational from lin_matriz, same cycle):
  - Equals the latched column when contact=1 and lin_matriz equals the latched row.
  - Otherwise 1111.
  - lin_matriz values that are not one-hot-low never match.
- Handshake:
  - A key is accepted when key_valid and key_ready are both 1 at a clk edge; key_code is latched.
  - key_ready=1 only in IDLE.
  - Invalid code (0xC-0xF): key_error=1 for the next cycle only; state stays IDLE; contact stays 0.
- States:
  - IDLE: on accept of a valid code -> PRESS_BOUNCE, or -> HOLD if BOUNCE_PHASES=0.
  - PRESS_BOUNCE:
    - Phase index p runs 0..BOUNCE_PHASES-1, each phase BOUNCE_PERIOD cycles.
    - contact = 1 when p is even, 0 when p is odd.
    - After the last phase -> HOLD.
  - HOLD: contact=1 for HOLD_CYCLES cycles -> REL_BOUNCE, or -> GAP if BOUNCE_PHASES=0.
  - REL_BOUNCE: same phase timing as PRESS_BOUNCE, but contact = 0 when p is even, 1 when p is odd; after the last phase -> GAP.
  - GAP: contact=0 for GAP_CYCLES cycles -> IDLE.
- Latency:
  - Accept at edge N -> contact=1 from cycle N+1.
  - First stable-closed cycle = N+1+BOUNCE_PHASES*BOUNCE_PERIOD.
  - key_ready returns 1 exactly 2*BOUNCE_PHASES*BOUNCE_PERIOD + HOLD_CYCLES + GAP_CYCLES cycles after N+1.
- busy = state != IDLE.
- key_abort:
  - Sampled in PRESS_BOUNCE, HOLD or REL_BOUNCE: contact=0 from the next cycle, go to GAP, restart the GAP count.
  - Ignored in IDLE and in GAP.
  - If key_abort and key_valid coincide in IDLE, the key is accepted.
- key_valid held high while key_ready=0 has no effect; no queuing.
- Counters use $clog2(max(param)+1) bits, saturate at 0, and never wrap.

Test Plan:
- Key '5' with defaults, scanner row strobe fixed at 1011:
  - col_matriz toggles 1011/1111 every 3 cycles for 6 phases, then is 1011 for 100 cycles.
  - Release bounce, then 1111.
  - key_ready returns 1 at N+1+196.
- Key '#' with lin_matriz rotating 0111->1011->1101->1110 each cycle during HOLD:
  - col_matriz = 1101 only in the 1110 cycles, 1111 otherwise.
- key_code=0xE:
  - key_error=1 for exactly one cycle; contact stays 0; key_ready stays 1; busy=0.
- key_abort asserted in HOLD cycle 40 of key '0':
  - contact=0 and col_matriz=1111 from the next cycle.
  - key_ready returns after exactly 60 cycles.
- rst pulsed during PRESS_BOUNCE of key '7':
  - From the next cycle contact=0, col_matriz=1111, key_ready=1, busy=0.
  - Next key '1' then sequences normally.
- BOUNCE_PHASES=0, keys 1,2,3 back-to-back with key_valid held high:
  - Three clean presses of 100 cycles each, separated by 60-cycle gaps.
  - Exactly three accepts.
